// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, an output register and
// a one-entry skid buffer, with redirect/flush handling of in-flight reads.
module fetch_stage #(
  parameter int unsigned          REGI_SIZE = 16,
  parameter logic [REGI_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [REGI_SIZE-1:0] redirect_pc_i,
  output logic                 imem_req_o,
  output logic [REGI_SIZE-1:0] imem_addr_o,
  input  logic                 imem_ack_i,
  input  logic [REGI_SIZE-1:0] imem_data_i,
  output logic                 valid_o,
  output logic [REGI_SIZE-1:0] instr_o,
  output logic [REGI_SIZE-1:0] next_pc_o
);

  typedef enum logic [1:0] {FETCH, SKID, FLUSH} state_t;

  state_t               state;
  logic [REGI_SIZE-1:0] pc;
  logic [REGI_SIZE-1:0] target;
  logic [REGI_SIZE-1:0] skid_instr;
  logic [REGI_SIZE-1:0] skid_next_pc;
  logic [REGI_SIZE-1:0] pc_inc;
  logic                 ack;
  logic                 out_free;
  logic                 consumed;

  // An ack only counts against a request actually on the bus, so acks seen
  // during reset or in SKID are ignored.
  assign ack         = imem_ack_i & imem_req_o;
  assign out_free    = ~valid_o | ~stall_i;
  assign consumed    = valid_o & ~stall_i;
  assign pc_inc      = pc + REGI_SIZE'(1);
  assign imem_addr_o = pc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      target       <= '0;
      skid_instr   <= '0;
      skid_next_pc <= '0;
      imem_req_o   <= 1'b0;
      valid_o      <= 1'b0;
      instr_o      <= '0;
      next_pc_o    <= '0;
    end else begin
      imem_req_o <= 1'b1;
      unique case (state)
        FETCH: begin
          if (redirect_i) begin
            valid_o <= 1'b0;
            // With no request on the bus (first cycle out of reset) there is
            // nothing to flush, so the target can be issued directly.
            if (ack || !imem_req_o) begin
              pc <= redirect_pc_i;
            end else begin
              target <= redirect_pc_i;
              state  <= FLUSH;
            end
          end else if (ack) begin
            pc <= pc_inc;
            if (out_free) begin
              instr_o   <= imem_data_i;
              next_pc_o <= pc_inc;
              valid_o   <= 1'b1;
            end else begin
              skid_instr   <= imem_data_i;
              skid_next_pc <= pc_inc;
              imem_req_o   <= 1'b0;
              state        <= SKID;
            end
          end else if (consumed) begin
            valid_o <= 1'b0;
          end
        end
        SKID: begin
          if (redirect_i) begin
            valid_o <= 1'b0;
            pc      <= redirect_pc_i;
            state   <= FETCH;
          end else if (!stall_i) begin
            instr_o   <= skid_instr;
            next_pc_o <= skid_next_pc;
            state     <= FETCH;
          end else begin
            imem_req_o <= 1'b0;
          end
        end
        FLUSH: begin
          if (ack) begin
            pc    <= redirect_i ? redirect_pc_i : target;
            state <= FETCH;
          end else if (redirect_i) begin
            target <= redirect_pc_i;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
